// File: rtl/multicrack_ctrl.sv
// multicrack_ctrl: supervises N_CORES parallel key-search engines. It starts
// them together, picks the lowest-indexed core that reports a key, stops the
// others, then copies that core's plaintext into a shared memory.
//
// Handshake: rdy=1 means the block is idle (IDLE, DONE or FAIL). en is
// sampled on a rising edge only while rdy=1 and starts a new run. en while
// rdy=0 is ignored. core_en and core_abort are single-cycle pulses.
module multicrack_ctrl #(
  parameter int N_CORES = 4,
  parameter int KEY_W = 24,
  localparam int IDX_W = (N_CORES > 2) ? $clog2(N_CORES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic                     rdy,
  output logic [KEY_W-1:0]         key,
  output logic                     key_valid,
  output logic [IDX_W-1:0]         winner,
  output logic [N_CORES-1:0]       core_en,
  output logic [N_CORES-1:0]       core_abort,
  input  logic [N_CORES-1:0]       core_rdy,
  input  logic [N_CORES-1:0]       core_key_valid,
  input  logic [N_CORES*KEY_W-1:0] core_key,
  input  logic [N_CORES*8-1:0]     core_msg_len,
  output logic [7:0]               core_pt_addr,
  input  logic [N_CORES*8-1:0]     core_pt_rddata,
  output logic [7:0]               pt_addr,
  output logic [7:0]               pt_wrdata,
  output logic                     pt_wren,
  output logic [2:0]               fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ARM    = 3'd2,
    S_SEARCH = 3'd3,
    S_COPY   = 3'd4,
    S_DONE   = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [N_CORES-1:0] found;
  logic               found_any;
  logic [IDX_W-1:0]   found_idx;
  logic [7:0]         len_q;
  logic [8:0]         k;
  logic               copy_last;
  logic               rd_issue;
  logic               wr_pend;
  logic               start;
  logic               all_rdy;

  assign found     = core_rdy & core_key_valid;
  assign all_rdy   = &core_rdy;
  // k is 9 bits so that len=255 reaches 256 without wrapping.
  assign copy_last = (k == ({1'b0, len_q} + 9'd1));
  assign fsm_state = state;

  // Lowest set found bit wins: scan downward so the lowest index is assigned last.
  always_comb begin
    found_any = 1'b0;
    found_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (found[i]) begin
        found_any = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_FAIL: if (en) state_nxt = S_LAUNCH;
      S_LAUNCH:               if (all_rdy) state_nxt = S_ARM;
      S_ARM:                  state_nxt = S_SEARCH;
      S_SEARCH: begin
        // A found bit takes precedence over the all-ready give-up.
        if (found_any)    state_nxt = S_COPY;
        else if (all_rdy) state_nxt = S_FAIL;
      end
      S_COPY:                 if (copy_last) state_nxt = S_DONE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state and live core status.
  always_comb begin
    rdy          = 1'b0;
    start        = 1'b0;
    core_en      = '0;
    core_abort   = '0;
    rd_issue     = 1'b0;
    core_pt_addr = 8'd0;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        rdy   = 1'b1;
        start = en;
      end
      S_LAUNCH: if (all_rdy) core_en = '1;
      S_SEARCH: begin
        if (found_any)
          core_abort = ~({{(N_CORES-1){1'b0}}, 1'b1} << found_idx);
      end
      S_COPY: begin
        rd_issue = (k <= {1'b0, len_q});
        if (rd_issue) core_pt_addr = k[7:0];
      end
      default: ;
    endcase
  end

  // Write port follows the read address by one cycle to match the memory latency.
  assign pt_wren   = wr_pend;
  assign pt_wrdata = wr_pend ? core_pt_rddata[winner*8 +: 8] : 8'd0;

  // Datapath: copy counter, delayed write address, latched result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k         <= 9'd0;
      wr_pend   <= 1'b0;
      pt_addr   <= 8'd0;
      key       <= '0;
      winner    <= '0;
      len_q     <= 8'd0;
      key_valid <= 1'b0;
    end else begin
      wr_pend <= rd_issue;
      pt_addr <= rd_issue ? k[7:0] : 8'd0;
      if (state == S_COPY) k <= k + 9'd1;
      else                 k <= 9'd0;
      if (start)
        key_valid <= 1'b0;
      else if (state == S_COPY && copy_last)
        key_valid <= 1'b1;
      if (state == S_SEARCH && found_any) begin
        key    <= core_key[found_idx*KEY_W +: KEY_W];
        winner <= found_idx;
        len_q  <= core_msg_len[found_idx*8 +: 8];
      end
    end
  end

endmodule

// File: doc/multicrack_ctrl.md
MULTICRACK_CTRL -- requirements
Module: multicrack_ctrl

Interface
- REQ-001 Parameter N_CORES, default 4, number of parallel crack engines supervised (legal 2..16).
- REQ-002 Parameter KEY_W, default 24, key width in bits.
- REQ-003 Derived parameter IDX_W = max(1, clog2(N_CORES)), width of the winner index.
- REQ-004 clk  in  1  clock; all state changes on rising edge.
- REQ-005 rst_n  in  1  reset, synchronous, active-low.
- REQ-006 en  in  1  start request; sampled only when rdy=1.
- REQ-007 rdy  out  1  block idle and able to accept en.
- REQ-008 key  out  KEY_W  recovered key; valid when key_valid=1.
- REQ-009 key_valid  out  1  key found and plaintext fully copied.
- REQ-010 winner  out  IDX_W  index of the core that supplied key.
- REQ-011 core_en  out  N_CORES  one-cycle start pulse per core.
- REQ-012 core_abort  out  N_CORES  one-cycle stop pulse to losing cores.
- REQ-013 core_rdy  in  N_CORES  per-core ready.
- REQ-014 core_key_valid  in  N_CORES  per-core key found; qualified by core_rdy.
- REQ-015 core_key  in  N_CORES*KEY_W  per-core key, core i in slice [i*KEY_W +: KEY_W].
- REQ-016 core_msg_len  in  N_CORES*8  per-core plaintext length byte.
- REQ-017 core_pt_addr  out  8  broadcast read address into all cores' plaintext memories.
- REQ-018 core_pt_rddata  in  N_CORES*8  per-core read data, one-cycle synchronous latency.
- REQ-019 pt_addr, pt_wrdata  out  8 each  shared plaintext memory write port.
- REQ-020 pt_wren  out  1  shared plaintext memory write enable.

Function
- REQ-021 FSM states SHALL be IDLE, LAUNCH, ARM, SEARCH, COPY, DONE, FAIL.
- REQ-022 rdy SHALL be 1 in IDLE/DONE/FAIL and 0 otherwise; en with rdy=1 SHALL move to LAUNCH next cycle and clear key_valid.
- REQ-023 LAUNCH: wait until &core_rdy=1, then drive core_en all-ones for exactly that one cycle and go to ARM.
- REQ-024 ARM: one dead cycle with core status ignored, then SEARCH.
- REQ-025 SEARCH: found[i] = core_rdy[i] & core_key_valid[i]; when any found, winner = lowest set index, latch key, winner and core_msg_len[winner], pulse core_abort for one cycle on all other cores, go to COPY.
- REQ-026 SEARCH: if &core_rdy=1 and no found bit set, go to FAIL; a found bit in the same cycle takes precedence over FAIL.
- REQ-027 COPY: 9-bit counter k from 0; cycle with k<=len drives core_pt_addr=k; one cycle later pt_addr=k, pt_wrdata=core_pt_rddata[winner], pt_wren=1.
- REQ-028 COPY SHALL transfer len+1 bytes (addresses 0..len) at one byte per cycle, last write len+2 cycles after COPY entry, then go to DONE.
- REQ-029 len=255 SHALL copy 256 bytes without counter wrap; len=0 SHALL copy exactly one byte.
- REQ-030 DONE: key_valid=1, key and winner held stable until next accepted en.
- REQ-031 FAIL: key_valid=0, key unchanged; new en accepted.
- REQ-032 en while rdy=0 SHALL be ignored; pt_wren SHALL be 0 outside COPY.

Reset
- REQ-033 rst_n=0 SHALL, at the next edge, force IDLE, rdy=1, key=0, winner=0, key_valid=0, k=0, with core_en, core_abort, pt_wren, core_pt_addr, pt_addr, pt_wrdata all 0.
- REQ-034 Reset mid-COPY SHALL stop writes at that edge; no partial-copy completion afterwards.

Verification
- REQ-035 N_CORES=4, en pulse, core 2 reports key 0x00A3F1 with len 5 -> core_abort=4'b1011 for one cycle, 6 writes to addresses 0..5 on consecutive cycles, then key=0x00A3F1, winner=2, key_valid=1, rdy=1.
- REQ-036 Cores 1 and 3 report found in the same cycle -> winner=1, key from core 1, core_abort=4'b1101.
- REQ-037 All cores return rdy with key_valid=0 -> FAIL, rdy=1, key_valid=0, pt_wren never asserted.
- REQ-038 Winner len=255 -> exactly 256 writes to addresses 0..255 with no wrap, then DONE.
- REQ-039 rst_n low during COPY at byte 3 -> next cycle pt_wren=0, rdy=1, key_valid=0; fresh en runs to completion.
- REQ-040 en held high during SEARCH and DONE -> ignored in SEARCH, restarts from DONE, core_en pulses once per accepted start.
